if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the PC and instruction width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous discard of all queued entries (branch/redirect).
REQ-007 in_valid  input  1  fetch stage offers {in_pc, in_inst}.
REQ-008 in_ready  output  1  queue accepts the offered entry this cycle.
REQ-009 in_pc  input  XLEN  PC of the fetched instruction.
REQ-010 in_inst  input  XLEN  fetched instruction word.
REQ-011 out_valid  output  1  head entry is presented to decode.
REQ-012 out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 out_pc  output  XLEN  PC of the head entry.
REQ-014 out_inst  output  XLEN  instruction of the head entry.
REQ-015 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-016 err_misalign  output  1  sticky flag, set when an accepted in_pc has in_pc[1:0] != 2'b00.

Function
REQ-017 Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 Occupancy SHALL be tracked by count; full when count == DEPTH, empty when count == 0.
REQ-019 Outputs:
- in_ready = !full && !flush (combinational).
- out_valid = !empty (registered state only).
REQ-020 Push occurs when in_valid && in_ready: the entry is written at the write pointer, and the write pointer advances by one.
REQ-021 Pop occurs when out_valid && out_ready && !flush: the read pointer advances by one.
REQ-022 out_pc and out_inst SHALL show the entry at the read pointer; they are don't-care while out_valid is 0.
REQ-023 Latency: there is no fall-through. An entry pushed in cycle N is visible at the output (out_valid=1) in cycle N+1 at the earliest.
REQ-024 count updates:
- push only: +1.
- pop only: -1.
- simultaneous push and pop: unchanged, both pointers advance.
REQ-025 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; there is no same-cycle slot reuse.
REQ-026 flush SHALL have priority over push and pop. At the next edge, both pointers reset to 0 and count becomes 0. Any concurrent in_valid and out_ready are ignored, so no entry is consumed.
REQ-027 flush SHALL NOT clear err_misalign.
REQ-028 err_misalign SHALL be set on the edge of an accepted misaligned push and SHALL stay 1 until reset.
REQ-029 Entry order SHALL be strict FIFO. No entry SHALL be duplicated or dropped except by flush.
REQ-030 Storage contents SHALL NOT need reset; only pointers, count and err_misalign are reset.

Reset
REQ-031 While rst_n is 0, the following SHALL hold asynchronously: read pointer = 0, write pointer = 0, count = 0, out_valid = 0, in_ready = 0, err_misalign = 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries. The first push after rst_n rises SHALL appear as the first output.
REQ-033 After reset release, in_ready SHALL be 1 in the first cycle (flush low).

Verification
REQ-034 Fill and drain: push pc 0x0, 0x4, 0x8, 0xC with out_ready=0.
- Expect count=4 and in_ready=0.
- A fifth push is not accepted.
- Then raise out_ready: four pops in order 0x0, 0x4, 0x8, 0xC, then out_valid=0 and count=0.
REQ-035 Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles, pc 0x100 upward in steps of 4.
- Expect out_valid from cycle 2.
- Output pcs are in order with no gaps.
- count stays at 1.
REQ-036 Full with pop: DEPTH entries queued, out_ready=1 and in_valid=1 in the same cycle.
- Expect one pop, no push, count=DEPTH-1.
- Next cycle the push is accepted and count=DEPTH.
REQ-037 Flush: 3 entries queued, flush=1 with in_valid=1 (pc 0x40) and out_ready=1.
- Next cycle: count=0, out_valid=0, pc 0x40 absent.
- The next push of pc 0x80 is the first output.
REQ-038 Misalign and reset: push pc 0x6.
- Expect err_misalign=1 the next cycle, still 1 after a flush.
- Assert rst_n=0 mid-cycle: err_misalign, count and out_valid drop to 0 immediately, without waiting for a clock edge.
REQ-039 Wrap-around: run 3*DEPTH pushes and pops with random out_ready.
- Pointers wrap.
- Output sequence matches input sequence exactly.

Source files
------------

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
// Handshake and payload bundle between fetch, the IF/ID queue and decode.
//   in_valid/in_ready/in_pc/in_inst     : fetch -> queue push channel
//   out_valid/out_ready/out_pc/out_inst : queue -> decode pop channel
// Modports:
//   slave  : the queue's view (consumes the push channel, drives the pop one)
//   master : the environment's view (fetch + decode side)
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Circular-buffer FIFO decoupling the fetch stage from decode. Entries are
// {pc, instruction} pairs. No fall-through: a pushed entry is visible to
// decode one cycle later at the earliest. flush discards everything and wins
// over push and pop. A sticky flag records any accepted misaligned PC.
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   flush        : synchronous discard of all entries
//   bus          : push/pop handshake bundle (slave modport)
//   count        : number of occupied entries (registered)
//   err_misalign : sticky, set by an accepted push with pc[1:0] != 0
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  if_id_queue_if.slave           bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // PC alignment check for 32-bit instructions
  function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [XLEN-1:0] inst_mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic            out_valid_r;
  logic            err_r;

  logic            full_s;
  logic            in_ready_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   count_nxt_s;

  // rst_n gating keeps in_ready low for the whole reset, not just until
  // count settles; a full queue never accepts, even when popping this cycle.
  assign full_s     = (count_r == FULL_COUNT);
  assign in_ready_s = rst_n && !full_s && !flush;
  assign push_s     = bus.in_valid && in_ready_s;
  assign pop_s      = out_valid_r && bus.out_ready && !flush;

  // Next occupancy from the push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Payload storage; not reset, only ever read under out_valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= bus.in_pc;
      inst_mem_r[wr_ptr_r] <= bus.in_inst;
    end
  end

  // Pointers, occupancy and head-valid; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
    end else if (flush) begin
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      // Power-of-two DEPTH lets the pointers wrap naturally
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
    end
  end

  // Sticky misalignment flag; survives flush, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (push_s && is_misaligned(bus.in_pc)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pc    = pc_mem_r[rd_ptr_r];
  assign bus.out_inst  = inst_mem_r[rd_ptr_r];
  assign count         = count_r;
  assign err_misalign  = err_r;

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
// Directed bench for if_id_queue. A queue-based reference model tracks the
// expected contents; a negedge process compares every DUT output with it.
// Directed phases add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic          err_misalign;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  if_id_queue_if #(.XLEN(XLEN)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .count        (count),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  // Reference model: expected contents as {pc, inst}
  logic [63:0] mq[$];
  logic [63:0] tmp;
  bit          m_err  = 1'b0;
  int          n_push = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    bit pp;
    if (!rst_n) begin
      mq.delete();
      m_err = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = bus.in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() > 0) && bus.out_ready;
      if (pp) tmp = mq.pop_front();
      if (acc) begin
        mq.push_back({bus.in_pc, bus.in_inst});
        n_push++;
        if (bus.in_pc[1:0] != 2'b00) m_err = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(rst_n && !flush && (mq.size() < DEPTH)));
      check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      check("count", 64'(count), 64'(mq.size()));
      check("err_misalign", 64'(err_misalign), 64'(m_err));
      if (mq.size() != 0) begin
        check("out_pc", 64'(bus.out_pc), 64'(mq[0][63:32]));
        check("out_inst", 64'(bus.out_inst), 64'(mq[0][31:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_inst  = ~pc ^ 32'h1357_9BDF;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base;
    int cyc;
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4));
      step();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h10);
    step();
    check("fifth_rejected", 64'(count), 64'd4);
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(bus.out_pc), 64'(i * 4));
      step();
    end
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    check("drain_count", 64'(count), 64'd0);

    // Streaming
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k));
      step();
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(bus.out_pc), 64'(32'h100 + 32'(4 * k)));
    end
    drive(1'b0, 32'h0);
    step();
    bus.out_ready = 1'b0;
    check("stream_empty", 64'(count), 64'd0);

    // Full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      step();
    end
    drive(1'b1, 32'h210);
    bus.out_ready = 1'b1;
    step();
    check("fullpop_count", 64'(count), 64'(DEPTH - 1));
    check("fullpop_head", 64'(bus.out_pc), 64'h204);
    bus.out_ready = 1'b0;
    step();
    check("fullpop_refill", 64'(count), 64'(DEPTH));
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    bus.out_ready = 1'b0;

    // Flush with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i));
      step();
    end
    drive(1'b1, 32'h40);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h80);
    step();
    drive(1'b0, 32'h0);
    check("post_flush_valid", 64'(bus.out_valid), 64'd1);
    check("post_flush_pc", 64'(bus.out_pc), 64'h80);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Misalign, flush persistence, mid-cycle reset
    check("err_clear", 64'(err_misalign), 64'd0);
    drive(1'b1, 32'h6);
    step();
    drive(1'b0, 32'h0);
    check("err_set", 64'(err_misalign), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("err_after_flush", 64'(err_misalign), 64'd1);
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_err", 64'(err_misalign), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 32'h600);
    step();
    drive(1'b0, 32'h0);
    check("first_after_rst_valid", 64'(bus.out_valid), 64'd1);
    check("first_after_rst_pc", 64'(bus.out_pc), 64'h600);
    bus.out_ready = 1'b1;
    step();

    // Wrap-around with random back-pressure
    n = 0;
    cyc = 0;
    while ((n < 3 * DEPTH || mq.size() != 0) && cyc < 400) begin
      drive(n < 3 * DEPTH, 32'h1000 + 32'(4 * n));
      bus.out_ready = 1'($urandom_range(0, 1));
      base = n_push;
      step();
      if (n_push != base) n++;
      cyc++;
    end
    drive(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    check("wrap_accepted", 64'(n), 64'(3 * DEPTH));
    check("wrap_drained", 64'(count), 64'd0);
    step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
